// File: rtl/usb_chk_pkg.sv
// Shared constants for the USB receive packet checker: PID classes, error codes,
// CRC parameters and FSM state encoding.
package usb_chk_pkg;

  typedef enum logic [1:0] {
    CLS_TOKEN = 2'd0,
    CLS_DATA  = 2'd1,
    CLS_HAND  = 2'd2,
    CLS_UNSUP = 2'd3
  } pid_class_e;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_PID   = 3'd1,
    ERR_CRC5  = 3'd2,
    ERR_CRC16 = 3'd3,
    ERR_LEN   = 3'd4,
    ERR_UNSUP = 3'd5
  } err_code_e;

  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_POLY   = 5'b00101;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  localparam logic [6:0]  LEN_MAX     = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PID    = 2'd1,
    ST_BODY   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  function automatic pid_class_e pid_class(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: return CLS_TOKEN;
      PID_DATA0, PID_DATA1:                return CLS_DATA;
      PID_ACK, PID_NAK, PID_STALL:         return CLS_HAND;
      default:                             return CLS_UNSUP;
    endcase
  endfunction

endpackage

// File: rtl/usb_chk_crc.sv
// Combinational byte-wide CRC5 and CRC16 update; bits are consumed LSB-first,
// matching the order they appeared on the wire.
module usb_chk_crc
  import usb_chk_pkg::*;
(
  input  logic [7:0]  i_data,
  input  logic [4:0]  i_crc5,
  input  logic [15:0] i_crc16,
  output logic [4:0]  o_crc5,
  output logic [15:0] o_crc16
);

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? CRC5_POLY : 5'd0);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC16_POLY : 16'd0);
    end
    return r;
  endfunction

  assign o_crc5  = crc5_byte(i_crc5, i_data);
  assign o_crc16 = crc16_byte(i_crc16, i_data);

endmodule

// File: rtl/usb_pkt_checker.sv
// Passive USB receive packet checker: PID, CRC5/CRC16 and length validation with
// saturating error/packet counters. Define USB_CHK_MAXLEN_EN to cap data packet length.
module usb_pkt_checker
  import usb_chk_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_active,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             clr,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pkt_count
);

`ifdef USB_CHK_MAXLEN_EN
  localparam logic [6:0] LEN_DATA_MAX = 7'd66;
`endif

  state_e      r_state;
  logic        r_pid_ok;
  pid_class_e  r_class;
  logic [6:0]  r_len;
  logic [4:0]  r_crc5;
  logic [15:0] r_crc16;

  logic [4:0]  w_crc5_nxt;
  logic [15:0] w_crc16_nxt;
  logic        w_len_bad;
  err_code_e   w_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [6:0] len_inc(input logic [6:0] v);
    return (v == LEN_MAX) ? v : v + 7'd1;
  endfunction

  usb_chk_crc u_crc (
    .i_data  (rx_data),
    .i_crc5  (r_crc5),
    .i_crc16 (r_crc16),
    .o_crc5  (w_crc5_nxt),
    .o_crc16 (w_crc16_nxt)
  );

  always_comb begin
    w_len_bad = 1'b0;
    case (r_class)
      CLS_TOKEN: w_len_bad = (r_len != 7'd2);
      CLS_HAND:  w_len_bad = (r_len != 7'd0);
`ifdef USB_CHK_MAXLEN_EN
      CLS_DATA:  w_len_bad = (r_len < 7'd2) || (r_len > LEN_DATA_MAX);
`else
      CLS_DATA:  w_len_bad = (r_len < 7'd2);
`endif
      default:   w_len_bad = 1'b0;
    endcase
  end

  always_comb begin
    w_err = ERR_NONE;
    if (!r_pid_ok)                                       w_err = ERR_PID;
    else if (r_class == CLS_UNSUP)                       w_err = ERR_UNSUP;
    else if (w_len_bad)                                  w_err = ERR_LEN;
    else if (r_class == CLS_TOKEN && r_crc5 != CRC5_RESID)  w_err = ERR_CRC5;
    else if (r_class == CLS_DATA && r_crc16 != CRC16_RESID) w_err = ERR_CRC16;
  end

  // Per-packet datapath; re-seeded every IDLE cycle, so it needs no reset
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE) begin
      r_len   <= '0;
      r_crc5  <= CRC5_INIT;
      r_crc16 <= CRC16_INIT;
    end else if (r_state == ST_PID && rx_active && rx_valid) begin
      r_pid_ok <= (rx_data[7:4] == ~rx_data[3:0]);
      r_class  <= pid_class(rx_data[3:0]);
    end else if (r_state == ST_BODY && rx_active && rx_valid) begin
      r_len   <= len_inc(r_len);
      r_crc5  <= w_crc5_nxt;
      r_crc16 <= w_crc16_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      err_valid <= 1'b0;
      err_code  <= 3'd0;
      err_count <= '0;
      pkt_count <= '0;
    end else begin
      err_valid <= 1'b0;
      err_code  <= 3'd0;
      if (clr) begin
        err_count <= '0;
        pkt_count <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (rx_active) r_state <= ST_PID;
        end
        ST_PID: begin
          // Packet ended before its PID arrived: drop it silently
          if (!rx_active)    r_state <= ST_IDLE;
          else if (rx_valid) r_state <= ST_BODY;
        end
        ST_BODY: begin
          if (!rx_active) r_state <= ST_REPORT;
        end
        ST_REPORT: begin
          r_state <= ST_IDLE;
          if (!clr) pkt_count <= sat_inc(pkt_count);
          if (w_err != ERR_NONE) begin
            err_valid <= 1'b1;
            err_code  <= w_err;
            if (!clr) err_count <= sat_inc(err_count);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
